traffic_receiver: RTL and testbench

- Receive-side endpoint for the local port of a router; the counterpart of the traffic generator.
- Accepts flits from the router over the i_rec_req/o_rec_ack handshake and buffers them.
- Checks packet framing (HEAD, BODY_COUNT x BODY, TAIL) and the head destination address against this node's coordinates.
- Reports completed packets, captured payload and error counts for bench/status use.

---
 rtl/traffic_receiver.sv | 246 ++++++++++++++++++++++++
 tb/tb_traffic_receiver.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_receiver.sv
// Receive endpoint for a router local port: buffers incoming flits, checks
// HEAD/BODY/TAIL framing and destination address, and reports status counters.
package router_pkg;

    typedef enum logic [1:0] {
        F_NONE = 2'd0,
        F_HEAD = 2'd1,
        F_BODY = 2'd2,
        F_TAIL = 2'd3
    } flit_type_t;

    localparam int FLIT_SIZE = 35;

    typedef struct packed {
        logic       valid;
        flit_type_t ftype;
        logic [7:0] xaddr;
        logic [7:0] yaddr;
        logic [15:0] rsvd;
    } head_flit_t;

    typedef struct packed {
        logic        valid;
        flit_type_t  ftype;
        logic [31:0] data;
    } body_flit_t;

    typedef struct packed {
        logic        valid;
        flit_type_t  ftype;
        logic [31:0] rsvd;
    } tail_flit_t;

    typedef union packed {
        head_flit_t head;
        body_flit_t body;
        tail_flit_t tail;
    } FLIT_t;

    typedef struct packed {
        int xaddr;
        int yaddr;
    } ROUTER_CONFIG;

endpackage

module traffic_receiver
    import router_pkg::*;
#(
    parameter int           BODY_COUNT  = 2,
    parameter ROUTER_CONFIG router_conf = '{default: 9999},
    parameter int           DEPTH       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  FLIT_t       i_flit,
    input  logic        i_rec_req,
    output logic        o_rec_ack,
    input  logic        i_drain_en,
    output logic        o_pkt_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [15:0] o_last_data,
    output logic [15:0] o_pkt_count,
    output logic [15:0] o_err_count,
    output logic        o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BODY_COUNT + 1);
    localparam logic [7:0] MY_X = 8'(router_conf.xaddr);
    localparam logic [7:0] MY_Y = 8'(router_conf.yaddr);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BODY_S = 2'd1,
        TAIL_S = 2'd2
    } state_t;

    // ---------------- input buffer (first-word-fall-through) ----------------
    FLIT_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, empty, wr_en, pop, ovf;
    FLIT_t         head_flit;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign o_rec_ack = ~full;
    assign wr_en     = i_rec_req & ~full & i_flit.head.valid;
    assign ovf       = i_rec_req &  full & i_flit.head.valid;
    assign pop       = ~empty & i_drain_en;
    assign head_flit = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= i_flit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- framing checker ----------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          addr_err_q, addr_err_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          fsm_err, good, start_pkt;
    logic [1:0]    fsm_code;

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_err_d = addr_err_q;
        shadow_d   = shadow_q;
        fsm_err    = 1'b0;
        fsm_code   = 2'd0;
        good       = 1'b0;
        start_pkt  = 1'b0;
        if (pop) begin
            case (state_q)
                IDLE: begin
                    if (head_flit.head.ftype == F_HEAD) begin
                        start_pkt = 1'b1;
                    end else begin
                        fsm_err  = 1'b1;
                        fsm_code = 2'd2;
                    end
                end
                BODY_S: begin
                    case (head_flit.head.ftype)
                        F_BODY: begin
                            cnt_d    = cnt_inc;
                            shadow_d = head_flit.body.data[15:0];
                            if (cnt_inc == CW'(BODY_COUNT)) state_d = TAIL_S;
                        end
                        F_HEAD: begin
                            fsm_err   = 1'b1;
                            fsm_code  = 2'd2;
                            start_pkt = 1'b1;
                        end
                        default: begin
                            fsm_err  = 1'b1;
                            fsm_code = 2'd2;
                            state_d  = IDLE;
                        end
                    endcase
                end
                TAIL_S: begin
                    case (head_flit.head.ftype)
                        F_TAIL: begin
                            if (addr_err_q) begin
                                fsm_err  = 1'b1;
                                fsm_code = 2'd1;
                            end else begin
                                good = 1'b1;
                            end
                            state_d = IDLE;
                        end
                        F_HEAD: begin
                            fsm_err   = 1'b1;
                            fsm_code  = 2'd2;
                            start_pkt = 1'b1;
                        end
                        default: begin
                            fsm_err  = 1'b1;
                            fsm_code = 2'd2;
                            state_d  = IDLE;
                        end
                    endcase
                end
                default: state_d = IDLE;
            endcase
            // A HEAD seen mid-packet is flagged above and then restarts framing.
            if (start_pkt) begin
                state_d    = BODY_S;
                cnt_d      = '0;
                addr_err_d = (head_flit.head.xaddr != MY_X) ||
                             (head_flit.head.yaddr != MY_Y);
            end
        end
    end

    // ---------------- registered status ----------------
    logic        pkt_done_q, err_q;
    logic [1:0]  err_code_q;
    logic [15:0] last_data_q, pkt_count_q, err_count_q;
    logic [16:0] err_sum;

    assign err_sum = {1'b0, err_count_q} + 17'(fsm_err) + 17'(ovf);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_err_q  <= 1'b0;
            shadow_q    <= '0;
            pkt_done_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            last_data_q <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_err_q <= addr_err_d;
            shadow_q   <= shadow_d;
            pkt_done_q <= good;
            err_q      <= fsm_err | ovf;
            if (fsm_err)  err_code_q <= fsm_code;
            else if (ovf) err_code_q <= 2'd3;
            if (good) begin
                last_data_q <= shadow_q;
                if (pkt_count_q != '1) pkt_count_q <= pkt_count_q + 16'd1;
            end
            err_count_q <= err_sum[16] ? '1 : err_sum[15:0];
        end
    end

    logic unused_valid;
    assign unused_valid = head_flit.head.valid;

    assign o_pkt_done  = pkt_done_q;
    assign o_err       = err_q;
    assign o_err_code  = err_code_q;
    assign o_last_data = last_data_q;
    assign o_pkt_count = pkt_count_q;
    assign o_err_count = err_count_q;
    assign o_busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_traffic_receiver.sv
// Bench for traffic_receiver: packet vector table plus hand-written corner
// sequences, with a scoreboard of expected completion/error events.
module tb_traffic_receiver;
    import router_pkg::*;

    localparam ROUTER_CONFIG CONF = '{xaddr: 3, yaddr: 3};

    logic        clk = 1'b0;
    logic        reset;
    FLIT_t       i_flit;
    logic        i_rec_req;
    logic        o_rec_ack;
    logic        i_drain_en;
    logic        o_pkt_done;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic [15:0] o_last_data;
    logic [15:0] o_pkt_count;
    logic [15:0] o_err_count;
    logic        o_busy;

    traffic_receiver #(
        .BODY_COUNT (2),
        .router_conf(CONF),
        .DEPTH      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_flit     (i_flit),
        .i_rec_req  (i_rec_req),
        .o_rec_ack  (o_rec_ack),
        .i_drain_en (i_drain_en),
        .o_pkt_done (o_pkt_done),
        .o_err      (o_err),
        .o_err_code (o_err_code),
        .o_last_data(o_last_data),
        .o_pkt_count(o_pkt_count),
        .o_err_count(o_err_count),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic        err;
        logic [1:0]  code;
        logic [15:0] last;
        logic [15:0] pcnt;
        logic [15:0] ecnt;
    } ev_t;

    ev_t sb[$];

    task automatic push(input logic err, input logic [1:0] code, input logic [15:0] last,
                        input logic [15:0] pcnt, input logic [15:0] ecnt);
        ev_t e;
        e.err = err; e.code = code; e.last = last; e.pcnt = pcnt; e.ecnt = ecnt;
        sb.push_back(e);
    endtask

    ev_t cur;
    always @(negedge clk) begin
        if (!reset && (o_pkt_done || o_err)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got done=%0b err=%0b code=%0d, expected no event",
                         o_pkt_done, o_err, o_err_code);
            end else begin
                cur = sb.pop_front();
                check("ev_err", int'(o_err), int'(cur.err));
                check("ev_done", int'(o_pkt_done), int'(!cur.err));
                if (cur.err) check("ev_code", int'(o_err_code), int'(cur.code));
                check("ev_last_data", int'(o_last_data), int'(cur.last));
                check("ev_pkt_count", int'(o_pkt_count), int'(cur.pcnt));
                check("ev_err_count", int'(o_err_count), int'(cur.ecnt));
            end
        end
    end

    function automatic FLIT_t mk_head(input logic [7:0] x, input logic [7:0] y);
        FLIT_t f;
        f = '0;
        f.head.valid = 1'b1;
        f.head.ftype = F_HEAD;
        f.head.xaddr = x;
        f.head.yaddr = y;
        return f;
    endfunction

    function automatic FLIT_t mk_body(input logic [15:0] d);
        FLIT_t f;
        f = '0;
        f.body.valid = 1'b1;
        f.body.ftype = F_BODY;
        f.body.data  = {16'hC0DE, d};
        return f;
    endfunction

    function automatic FLIT_t mk_tail();
        FLIT_t f;
        f = '0;
        f.tail.valid = 1'b1;
        f.tail.ftype = F_TAIL;
        return f;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that wrote the flit.
    task automatic send_flit(input FLIT_t f);
        int w;
        w = 0;
        i_flit    = f;
        i_rec_req = 1'b1;
        while (!o_rec_ack && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!o_rec_ack) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: got ack=0 for 50 cycles, expected ack=1");
        end
        @(posedge clk); #1;
        i_rec_req = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] x, input logic [7:0] y,
                            input logic [15:0] d0, input logic [15:0] d1);
        send_flit(mk_head(x, y));
        send_flit(mk_body(d0));
        send_flit(mk_body(d1));
        send_flit(mk_tail());
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while ((o_busy || sb.size() != 0) && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (2) begin @(posedge clk); #1; end
        check({name, "_busy"}, int'(o_busy), 0);
        check({name, "_sb_drained"}, sb.size(), 0);
    endtask

    typedef struct {
        logic        has_head;
        logic [7:0]  x;
        logic [7:0]  y;
        int          nbody;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        err;
        logic [1:0]  code;
        logic [15:0] last;
        logic [15:0] pcnt;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 8'd3, 8'd3, 2, 16'h0011, 16'h0012, 1'b0, 2'd0, 16'h0012, 16'd1, 16'd0};
        tbl[1] = '{1'b1, 8'd1, 8'd2, 2, 16'h0021, 16'h0022, 1'b1, 2'd1, 16'h0012, 16'd1, 16'd1};
        tbl[2] = '{1'b1, 8'd3, 8'd3, 1, 16'h0031, 16'h0000, 1'b1, 2'd2, 16'h0012, 16'd1, 16'd2};
        tbl[3] = '{1'b1, 8'd3, 8'd3, 2, 16'h0041, 16'h0042, 1'b0, 2'd0, 16'h0042, 16'd2, 16'd2};
        tbl[4] = '{1'b0, 8'd0, 8'd0, 0, 16'h0000, 16'h0000, 1'b1, 2'd2, 16'h0042, 16'd2, 16'd3};
        tbl[5] = '{1'b1, 8'd3, 8'd4, 2, 16'h0051, 16'h0052, 1'b1, 2'd1, 16'h0042, 16'd2, 16'd4};
        tbl[6] = '{1'b1, 8'd3, 8'd3, 2, 16'h7777, 16'hBEEF, 1'b0, 2'd0, 16'hBEEF, 16'd3, 16'd4};

        reset      = 1'b1;
        i_flit     = '0;
        i_rec_req  = 1'b0;
        i_drain_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", int'(o_rec_ack), 1);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_pkt_done), 0);
        check("rst_err", int'(o_err), 0);
        check("rst_code", int'(o_err_code), 0);
        check("rst_last", int'(o_last_data), 0);
        check("rst_pcnt", int'(o_pkt_count), 0);
        check("rst_ecnt", int'(o_err_count), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Valid=0 requests are ignored entirely.
        i_flit    = mk_tail();
        i_flit.tail.valid = 1'b0;
        i_rec_req = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        i_rec_req = 1'b0;
        check("invalid_busy", int'(o_busy), 0);
        check("invalid_ecnt", int'(o_err_count), 0);

        for (int i = 0; i < 7; i++) begin
            push(tbl[i].err, tbl[i].code, tbl[i].last, tbl[i].pcnt, tbl[i].ecnt);
            if (tbl[i].has_head) send_flit(mk_head(tbl[i].x, tbl[i].y));
            if (tbl[i].nbody >= 1) send_flit(mk_body(tbl[i].d0));
            if (tbl[i].nbody >= 2) send_flit(mk_body(tbl[i].d1));
            send_flit(mk_tail());
        end
        wait_idle("table");

        // HEAD inside BODY_S: flagged, then restarts as a fresh packet.
        push(1'b1, 2'd2, 16'hBEEF, 16'd3, 16'd5);
        push(1'b0, 2'd0, 16'h0063, 16'd4, 16'd5);
        send_flit(mk_head(8'd3, 8'd3));
        send_flit(mk_body(16'h0061));
        send_pkt(8'd3, 8'd3, 16'h0062, 16'h0063);
        wait_idle("restart");

        // Fill the buffer with draining stalled, then attempt a fifth write.
        i_drain_en = 1'b0;
        send_pkt(8'd3, 8'd3, 16'h0071, 16'h0072);
        check("full_ack", int'(o_rec_ack), 0);
        check("full_busy", int'(o_busy), 1);
        push(1'b1, 2'd3, 16'h0063, 16'd4, 16'd6);
        push(1'b0, 2'd0, 16'h0072, 16'd5, 16'd6);
        i_flit    = mk_head(8'd3, 8'd3);
        i_rec_req = 1'b1;
        @(posedge clk); #1;
        i_rec_req = 1'b0;
        i_drain_en = 1'b1;
        wait_idle("overflow");
        check("code_held", int'(o_err_code), 3);

        // Overflow and FSM error in the same cycle: +2 errors, one pulse.
        i_drain_en = 1'b0;
        for (int i = 0; i < 4; i++) send_flit(mk_tail());
        push(1'b1, 2'd2, 16'h0072, 16'd5, 16'd8);
        push(1'b1, 2'd2, 16'h0072, 16'd5, 16'd9);
        push(1'b1, 2'd2, 16'h0072, 16'd5, 16'd10);
        push(1'b1, 2'd2, 16'h0072, 16'd5, 16'd11);
        i_drain_en = 1'b1;
        i_flit     = mk_tail();
        i_rec_req  = 1'b1;
        @(posedge clk); #1;
        i_rec_req = 1'b0;
        wait_idle("simul");

        // Reset with a partial packet buffered.
        i_drain_en = 1'b0;
        send_flit(mk_head(8'd3, 8'd3));
        send_flit(mk_body(16'h0085));
        check("pre_rst_busy", int'(o_busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_busy", int'(o_busy), 0);
        check("mid_rst_ack", int'(o_rec_ack), 1);
        check("mid_rst_pcnt", int'(o_pkt_count), 0);
        check("mid_rst_ecnt", int'(o_err_count), 0);
        check("mid_rst_last", int'(o_last_data), 0);
        check("mid_rst_code", int'(o_err_code), 0);
        i_drain_en = 1'b1;
        push(1'b0, 2'd0, 16'h0082, 16'd1, 16'd0);
        send_pkt(8'd3, 8'd3, 16'h0081, 16'h0082);
        wait_idle("post_rst");

        // Packet counter saturation.
        force dut.pkt_count_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.pkt_count_q;
        push(1'b0, 2'd0, 16'h0092, 16'hFFFF, 16'd0);
        send_pkt(8'd3, 8'd3, 16'h0091, 16'h0092);
        push(1'b0, 2'd0, 16'h00A2, 16'hFFFF, 16'd0);
        send_pkt(8'd3, 8'd3, 16'h00A1, 16'h00A2);
        wait_idle("saturate");
        check("sat_pcnt", int'(o_pkt_count), 16'hFFFF);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
